// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the single register-file write port among NUM_REQ writeback
// requesters (e.g. ALU, load unit, CSR unit). A rotating round-robin pointer
// picks one valid requester per cycle. The winning write is registered, so
// the register-file write port is always driven from flops. The write that
// is currently on that port is forwarded onto both decode read ports, so
// decode never sees stale data in the cycle the write lands.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   stall_i                  blocks new grants while high
//   req_valid_i/req_ready_o  per-requester handshake (ready is one-hot or zero)
//   req_rd_i, req_data_i     packed per-requester destination index and data
//   w_en_o, rd_id_o,
//   rd_write_data_o          registered register-file write port
//   rs1_id_i, rs2_id_i       decode read indices
//   rs*_rf_rdata_i           raw register-file read data
//   rs*_rdata_o              read data with the in-flight write forwarded
//   grant_cnt_o              accepted requests since reset (wraps)
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*ADDR_W-1:0] req_rd_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic                      w_en_o,
  output logic [ADDR_W-1:0]         rd_id_o,
  output logic [DATA_W-1:0]         rd_write_data_o,
  input  logic [ADDR_W-1:0]         rs1_id_i,
  input  logic [ADDR_W-1:0]         rs2_id_i,
  input  logic [DATA_W-1:0]         rs1_rf_rdata_i,
  input  logic [DATA_W-1:0]         rs2_rf_rdata_i,
  output logic [DATA_W-1:0]         rs1_rdata_o,
  output logic [DATA_W-1:0]         rs2_rdata_o,
  output logic [31:0]               grant_cnt_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  win_idx;
  logic [PTR_W-1:0]  next_ptr;
  logic              win_found;
  logic [ADDR_W-1:0] win_rd;
  logic [DATA_W-1:0] win_data;

  // Round-robin pick. The first pass only considers requesters at or above
  // the pointer and the second pass considers all of them, which yields the
  // scan order ptr..NUM_REQ-1, 0..ptr-1 using constant indices only. The
  // grant looks at valids, pointer, stall and reset only, never at data.
  always_comb begin
    req_ready_o = '0;
    win_found   = 1'b0;
    win_idx     = '0;
    win_rd      = '0;
    win_data    = '0;
    if (!stall_i && !rst) begin
      for (int pass = 0; pass < 2; pass++) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!win_found && req_valid_i[i] &&
              (pass == 1 || PTR_W'(i) >= ptr)) begin
            win_found      = 1'b1;
            req_ready_o[i] = 1'b1;
            win_idx        = PTR_W'(i);
            win_rd         = req_rd_i[i*ADDR_W +: ADDR_W];
            win_data       = req_data_i[i*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  assign next_ptr = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  // Output stage. w_en_o is a one-cycle pulse per transfer; index and data
  // hold between transfers. Writes to x0 still count and rotate the pointer
  // but never raise the write enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_en_o          <= 1'b0;
      rd_id_o         <= '0;
      rd_write_data_o <= '0;
      ptr             <= '0;
      grant_cnt_o     <= '0;
    end else begin
      w_en_o <= 1'b0;
      if (win_found) begin
        rd_id_o         <= win_rd;
        rd_write_data_o <= win_data;
        w_en_o          <= (win_rd != '0);
        ptr             <= next_ptr;
        grant_cnt_o     <= grant_cnt_o + 32'd1;
      end
    end
  end

  // Bypass the write that is on the port this cycle; x0 always reads zero.
  assign rs1_rdata_o = (rs1_id_i == '0) ? '0 :
                       (w_en_o && rd_id_o == rs1_id_i) ? rd_write_data_o :
                       rs1_rf_rdata_i;
  assign rs2_rdata_o = (rs2_id_i == '0) ? '0 :
                       (w_en_o && rd_id_o == rs2_id_i) ? rd_write_data_o :
                       rs2_rf_rdata_i;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
// Directed bench for regfile_wb_arbiter (3 requesters). Each step drives the
// inputs after a falling edge, checks the combinational grant against the
// value the step expects, pushes the expected registered result to a
// scoreboard, and pops/compares it at the next falling edge.
module tb_regfile_wb_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  typedef struct packed {
    logic          w_en;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    logic [31:0]   cnt;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            stall;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_rd;
  logic [N*DW-1:0] req_data;
  logic            w_en;
  logic [AW-1:0]   rd_id;
  logic [DW-1:0]   rd_write_data;
  logic [AW-1:0]   rs1_id, rs2_id;
  logic [DW-1:0]   rs1_rf, rs2_rf;
  logic [DW-1:0]   rs1_rdata, rs2_rdata;
  logic [31:0]     grant_cnt;

  logic [AW-1:0]   rd_tab [N];
  logic [DW-1:0]   data_tab [N];

  exp_t            sb [$];
  logic [31:0]     exp_cnt;
  logic [AW-1:0]   last_rd;
  logic [DW-1:0]   last_data;
  int              compared   = 0;
  int              mismatched = 0;

  assign req_rd   = {rd_tab[2], rd_tab[1], rd_tab[0]};
  assign req_data = {data_tab[2], data_tab[1], data_tab[0]};

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_rd_i        (req_rd),
    .req_data_i      (req_data),
    .w_en_o          (w_en),
    .rd_id_o         (rd_id),
    .rd_write_data_o (rd_write_data),
    .rs1_id_i        (rs1_id),
    .rs2_id_i        (rs2_id),
    .rs1_rf_rdata_i  (rs1_rf),
    .rs2_rf_rdata_i  (rs2_rf),
    .rs1_rdata_o     (rs1_rdata),
    .rs2_rdata_o     (rs2_rdata),
    .grant_cnt_o     (grant_cnt)
  );

  task automatic compareVal(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Read-port value decode should see, given the write the bench expects on
  // the register-file port.
  function automatic logic [DW-1:0] fwd(input logic [AW-1:0] id,
                                        input logic [DW-1:0] rf,
                                        input exp_t e);
    if (id == '0) return '0;
    if (e.w_en && e.rd == id) return e.data;
    return rf;
  endfunction

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      compareVal("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    compareVal("w_en", {31'b0, w_en}, {31'b0, e.w_en});
    compareVal("rd_id", {27'b0, rd_id}, {27'b0, e.rd});
    compareVal("rd_write_data", rd_write_data, e.data);
    compareVal("grant_cnt", grant_cnt, e.cnt);
    compareVal("rs1_rdata", rs1_rdata, fwd(rs1_id, rs1_rf, e));
    compareVal("rs2_rdata", rs2_rdata, fwd(rs2_id, rs2_rf, e));
  endtask

  // One clock of stimulus: drive, check the grant, queue the expected
  // registered result, then compare it after the rising edge.
  task automatic applyStimulus(input logic rst_v, input logic stall_v,
                               input logic [N-1:0] valid_v,
                               input logic [N-1:0] exp_ready);
    exp_t e;
    rst       = rst_v;
    stall     = stall_v;
    req_valid = valid_v;
    #1;
    compareVal("req_ready", {29'b0, req_ready}, {29'b0, exp_ready});
    e.w_en = 1'b0;
    e.rd   = last_rd;
    e.data = last_data;
    if (rst_v) begin
      e.rd    = '0;
      e.data  = '0;
      exp_cnt = '0;
    end else if (exp_ready != '0) begin
      for (int k = 0; k < N; k++) begin
        if (exp_ready[k]) begin
          e.rd   = rd_tab[k];
          e.data = data_tab[k];
          e.w_en = (rd_tab[k] != '0);
        end
      end
      exp_cnt = exp_cnt + 32'd1;
    end
    e.cnt     = exp_cnt;
    last_rd   = e.rd;
    last_data = e.data;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    stall       = 1'b0;
    req_valid   = '0;
    rd_tab      = '{5'd1, 5'd2, 5'd3};
    data_tab    = '{32'hA, 32'hB, 32'hC};
    rs1_id      = 5'd1;
    rs2_id      = 5'd3;
    rs1_rf      = 32'h1111_1111;
    rs2_rf      = 32'h2222_2222;
    exp_cnt     = '0;
    last_rd     = '0;
    last_data   = '0;
    @(negedge clk);

    // Reset; valid requests during reset must not be granted
    applyStimulus(1'b1, 1'b0, 3'b000, 3'b000);
    applyStimulus(1'b1, 1'b0, 3'b111, 3'b000);

    // All valid: rotate 0,1,2,0 (pointer ends at 1, count 4)
    applyStimulus(1'b0, 1'b0, 3'b111, 3'b001);
    applyStimulus(1'b0, 1'b0, 3'b111, 3'b010);
    applyStimulus(1'b0, 1'b0, 3'b111, 3'b100);
    applyStimulus(1'b0, 1'b0, 3'b111, 3'b001);

    // Grant 1 (pointer -> 2), then 0 and 1 wrap around, then 2 alone
    applyStimulus(1'b0, 1'b0, 3'b010, 3'b010);
    applyStimulus(1'b0, 1'b0, 3'b011, 3'b001);
    applyStimulus(1'b0, 1'b0, 3'b011, 3'b010);
    applyStimulus(1'b0, 1'b0, 3'b100, 3'b100);

    // x0 write from requester 1: granted and counted, no write enable
    rd_tab[1]   = 5'd0;
    data_tab[1] = 32'hDEAD;
    applyStimulus(1'b0, 1'b0, 3'b010, 3'b010);

    // Forwarding of rd=5 onto rs1, rs2 reads x0
    rd_tab[2]   = 5'd5;
    data_tab[2] = 32'h1234;
    rs1_id      = 5'd5;
    rs2_id      = 5'd0;
    rs1_rf      = 32'h0;
    applyStimulus(1'b0, 1'b0, 3'b100, 3'b100);
    rs1_rf      = 32'h7777;
    applyStimulus(1'b0, 1'b0, 3'b000, 3'b000);

    // Stall for three cycles after a grant, then resume at saved pointer
    rd_tab[1]   = 5'd2;
    data_tab[1] = 32'hB;
    rs1_id      = 5'd1;
    rs2_id      = 5'd2;
    applyStimulus(1'b0, 1'b0, 3'b111, 3'b001);
    applyStimulus(1'b0, 1'b1, 3'b111, 3'b000);
    applyStimulus(1'b0, 1'b1, 3'b111, 3'b000);
    applyStimulus(1'b0, 1'b1, 3'b111, 3'b000);
    applyStimulus(1'b0, 1'b0, 3'b111, 3'b010);

    // Grant rd=7 from requester 0 (pointer -> 1), then reset drops it
    rd_tab[0]   = 5'd7;
    data_tab[0] = 32'h77;
    rs2_id      = 5'd7;
    applyStimulus(1'b0, 1'b0, 3'b001, 3'b001);
    applyStimulus(1'b1, 1'b0, 3'b111, 3'b000);
    applyStimulus(1'b0, 1'b0, 3'b111, 3'b001);

    compareVal("scoreboard_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
